// File: rtl/falafel_mem_responder_pkg.sv
// Shared types, constants and helpers for the falafel memory responder.
package falafel_mem_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int WORD_SIZE       = 4;
    localparam int MEM_DEPTH_WORDS = 1024;

    // One buffered response: the word returned to the initiator.
    typedef struct packed {
        logic [DATA_W-1:0] data;
    } mem_rsp_entry_t;

    // True when a byte address lands on a word boundary.
    function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/falafel_mem_responder_if.sv
// Request/response handshake bundle between the allocator core and the responder.
interface falafel_mem_responder_if #(
    parameter int DATA_W = falafel_mem_responder_pkg::DATA_W
);

    logic              mem_req_val_i;
    logic              mem_req_rdy_o;
    logic              mem_req_is_write_i;
    logic [DATA_W-1:0] mem_req_addr_i;
    logic [DATA_W-1:0] mem_req_data_i;
    logic              mem_rsp_val_o;
    logic              mem_rsp_rdy_i;
    logic [DATA_W-1:0] mem_rsp_data_o;

    // Initiator side (allocator core or testbench).
    modport master (
        output mem_req_val_i, mem_req_is_write_i, mem_req_addr_i, mem_req_data_i,
        output mem_rsp_rdy_i,
        input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
    );

    // Responder side.
    modport slave (
        input  mem_req_val_i, mem_req_is_write_i, mem_req_addr_i, mem_req_data_i,
        input  mem_rsp_rdy_i,
        output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
    );

endinterface

// File: rtl/falafel_rsp_fifo.sv
// Circular response buffer; head entry is presented combinationally, zero when empty.
module falafel_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] storage_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || do_pop_s);

    // Head presentation: drive zero while empty so stale data never leaks out.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = storage_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            storage_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/falafel_mem_responder.sv
// Word RAM responder: fixed-latency pipeline into an in-order response buffer with credit flow control.
module falafel_mem_responder #(
    parameter int DATA_W         = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int LATENCY        = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    falafel_mem_responder_if.slave  mem,
    output logic                    err_o
);

    import falafel_mem_responder_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] BYTE_LIMIT = DATA_W'(DEPTH_WORDS * WORD_SIZE);

    logic [DATA_W-1:0] ram_r [DEPTH_WORDS];

    logic              accept_s;
    logic              req_ok_s;
    logic [AW-1:0]     word_idx_s;
    logic [DATA_W-1:0] rsp_data_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW-1:0]     in_flight_r;
    logic [CW:0]       credits_used_s;
    logic              err_r;
    mem_rsp_entry_t    fifo_din_s;
    mem_rsp_entry_t    fifo_dout_s;

    assign word_idx_s = mem.mem_req_addr_i[AW+1:2];
    assign req_ok_s   = is_word_aligned(mem.mem_req_addr_i) && (mem.mem_req_addr_i < BYTE_LIMIT);

    // Every pipeline slot and buffer entry is a credit; ready only looks at registered state.
    assign credits_used_s    = {1'b0, in_flight_r} + {1'b0, fifo_count_s};
    assign mem.mem_req_rdy_o = (credits_used_s < (CW+1)'(RSP_FIFO_DEPTH)) && !fifo_full_s;
    assign accept_s          = mem.mem_req_val_i && mem.mem_req_rdy_o;

    // Response word for the request being accepted: write echo, RAM word, or zero if invalid.
    always_comb begin
        rsp_data_s = '0;
        if (!req_ok_s) begin
            rsp_data_s = '0;
        end else if (mem.mem_req_is_write_i) begin
            rsp_data_s = mem.mem_req_data_i;
        end else begin
            rsp_data_s = ram_r[word_idx_s];
        end
    end

    // Heap storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (accept_s && mem.mem_req_is_write_i && req_ok_s) begin
            ram_r[word_idx_s] <= mem.mem_req_data_i;
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            // The buffer register itself supplies the single cycle of latency.
            assign fifo_push_s = accept_s;
            assign fifo_din_s  = '{data: rsp_data_s};
        end else begin : g_pipe
            logic [LATENCY-2:0]             stage_val_r;
            logic [LATENCY-2:0][DATA_W-1:0] stage_data_r;

            // Delay line of LATENCY-1 stages; the buffer register adds the last cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stage_val_r  <= '0;
                    stage_data_r <= '0;
                end else begin
                    stage_val_r[0]  <= accept_s;
                    stage_data_r[0] <= rsp_data_s;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        stage_val_r[k]  <= stage_val_r[k-1];
                        stage_data_r[k] <= stage_data_r[k-1];
                    end
                end
            end

            assign fifo_push_s = stage_val_r[LATENCY-2];
            assign fifo_din_s  = '{data: stage_data_r[LATENCY-2]};
        end
    endgenerate

    // Count of accepted requests still travelling through the delay line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_flight_r <= '0;
        end else begin
            case ({accept_s, fifo_push_s})
                2'b10:   in_flight_r <= in_flight_r + CW'(1);
                2'b01:   in_flight_r <= in_flight_r - CW'(1);
                default: in_flight_r <= in_flight_r;
            endcase
        end
    end

    // Sticky error flag raised by any misaligned or out-of-range request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (accept_s && !req_ok_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o              = err_r;
    assign fifo_pop_s         = !fifo_empty_s && mem.mem_rsp_rdy_i;
    assign mem.mem_rsp_val_o  = !fifo_empty_s;
    assign mem.mem_rsp_data_o = fifo_dout_s.data;

    falafel_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH ($bits(mem_rsp_entry_t))
    ) u_rsp_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push_s),
        .din   (fifo_din_s),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed scoreboard bench for falafel_mem_responder.
module tb_falafel_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
    } sb_entry_t;

    logic clk;
    logic rst;
    logic err;
    int   cyc;
    int   checks;
    int   errors;
    int   last_lat;
    int   pp_seen;
    logic pp_armed;
    logic [2:0] pp_cnt;

    sb_entry_t   sb_q [$];
    int          rsp_log [$];
    logic [31:0] model [0:1023];

    falafel_mem_responder_if #(.DATA_W(32)) mem_if ();

    falafel_mem_responder #(
        .DATA_W         (32),
        .DEPTH_WORDS    (1024),
        .LATENCY        (LAT),
        .RSP_FIFO_DEPTH (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mem   (mem_if.slave),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake and checks push+pop occupancy.
    always @(negedge clk) begin
        if (pp_armed) begin
            chk("fifo_count_push_pop", {29'd0, dut.fifo_count_s}, {29'd0, pp_cnt});
            pp_armed = 1'b0;
            pp_seen++;
        end
        if (!rst && dut.fifo_push_s === 1'b1 && dut.fifo_pop_s === 1'b1) begin
            pp_armed = 1'b1;
            pp_cnt   = dut.fifo_count_s;
        end
        if (!rst && mem_if.mem_rsp_val_o === 1'b1 && mem_if.mem_rsp_rdy_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", mem_if.mem_rsp_val_o, 1'b0);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                chk("rsp_data", mem_if.mem_rsp_data_o, e.data);
                last_lat = cyc - e.acc_cyc;
                chk("rsp_latency_min", {31'd0, (last_lat >= LAT)}, 32'd1);
                rsp_log.push_back(cyc);
            end
        end
    end

    // Issue one request, wait (bounded) for acceptance, and record the expected response.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          waitc;
        sb_entry_t   e;
        logic        ok;
        waitc = 0;
        mem_if.mem_req_val_i      = 1'b1;
        mem_if.mem_req_is_write_i = w;
        mem_if.mem_req_addr_i     = a;
        mem_if.mem_req_data_i     = d;
        @(negedge clk);
        while (mem_if.mem_req_rdy_o !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (mem_if.mem_req_rdy_o !== 1'b1) begin
            chk("req_accept_timeout", {31'd0, mem_if.mem_req_rdy_o}, 32'd1);
            mem_if.mem_req_val_i = 1'b0;
            return;
        end
        ok = (a[1:0] == 2'b00) && (a < 32'h0000_1000);
        if (!ok) begin
            e.data = 32'h0;
        end else if (w) begin
            e.data          = d;
            model[a[11:2]]  = d;
        end else begin
            e.data = model[a[11:2]];
        end
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Stop requesting and wait (bounded) until every expected response has been seen.
    task automatic drain();
        int waitc;
        waitc = 0;
        mem_if.mem_req_val_i = 1'b0;
        while (sb_q.size() != 0 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_outstanding", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          pp0;
        logic [31:0] head;

        cyc = 0; checks = 0; errors = 0; last_lat = 0; pp_seen = 0; pp_armed = 1'b0; pp_cnt = 3'd0;
        rst = 1'b1;
        mem_if.mem_req_val_i      = 1'b0;
        mem_if.mem_req_is_write_i = 1'b0;
        mem_if.mem_req_addr_i     = 32'h0;
        mem_if.mem_req_data_i     = 32'h0;
        mem_if.mem_rsp_rdy_i      = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_val", {31'd0, mem_if.mem_rsp_val_o}, 32'd0);
        chk("reset_rsp_data", mem_if.mem_rsp_data_o, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_rdy", {31'd0, mem_if.mem_req_rdy_o}, 32'd1);
        @(posedge clk); #1;

        // Write then read back 0x40.
        send(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        send(1'b0, 32'h0000_0040, 32'h0);
        drain();
        chk("read_latency", last_lat, LAT);
        chk("err_clean_1", {31'd0, err}, 32'd0);

        // Back-to-back writes and reads with no bubbles.
        n0 = rsp_log.size();
        send(1'b1, 32'h0, 32'd1);
        send(1'b1, 32'h4, 32'd2);
        send(1'b1, 32'h8, 32'd3);
        send(1'b0, 32'h0, 32'd0);
        send(1'b0, 32'h4, 32'd0);
        send(1'b0, 32'h8, 32'd0);
        drain();
        chk("b2b_rsp_count", rsp_log.size() - n0, 32'd6);
        chk("b2b_rsp_span", rsp_log[n0+5] - rsp_log[n0], 32'd5);

        // Backpressure: four credits, then stall until the initiator drains.
        mem_if.mem_rsp_rdy_i = 1'b0;
        send(1'b0, 32'h0,  32'd0);
        send(1'b0, 32'h4,  32'd0);
        send(1'b0, 32'h8,  32'd0);
        send(1'b0, 32'h40, 32'd0);
        mem_if.mem_req_val_i      = 1'b1;
        mem_if.mem_req_is_write_i = 1'b0;
        mem_if.mem_req_addr_i     = 32'h4;
        @(negedge clk);
        chk("credit_req_rdy_low", {31'd0, mem_if.mem_req_rdy_o}, 32'd0);
        repeat (3) @(negedge clk);
        chk("stall_rsp_val", {31'd0, mem_if.mem_rsp_val_o}, 32'd1);
        chk("stall_head_data", mem_if.mem_rsp_data_o, sb_q[0].data);
        head = mem_if.mem_rsp_data_o;
        repeat (2) @(negedge clk);
        chk("stall_head_stable", mem_if.mem_rsp_data_o, head);
        chk("stall_req_rdy_low", {31'd0, mem_if.mem_req_rdy_o}, 32'd0);
        chk("stall_fifo_count", {29'd0, dut.fifo_count_s}, 32'd4);
        @(posedge clk); #1;
        mem_if.mem_rsp_rdy_i = 1'b1;
        send(1'b0, 32'h4, 32'd0);
        send(1'b0, 32'h8, 32'd0);
        drain();

        // Fill, then stream with simultaneous push and pop across the pointer wrap.
        mem_if.mem_rsp_rdy_i = 1'b0;
        send(1'b1, 32'h10, 32'h0000_00A0);
        send(1'b1, 32'h14, 32'h0000_00A1);
        send(1'b1, 32'h18, 32'h0000_00A2);
        send(1'b1, 32'h1C, 32'h0000_00A3);
        mem_if.mem_req_val_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_fifo_count", {29'd0, dut.fifo_count_s}, 32'd4);
        chk("full_req_rdy_low", {31'd0, mem_if.mem_req_rdy_o}, 32'd0);
        @(posedge clk); #1;
        pp0 = pp_seen;
        mem_if.mem_rsp_rdy_i = 1'b1;
        send(1'b0, 32'h10, 32'd0);
        send(1'b0, 32'h14, 32'd0);
        send(1'b0, 32'h18, 32'd0);
        send(1'b0, 32'h1C, 32'd0);
        drain();
        chk("push_pop_seen", {31'd0, (pp_seen > pp0)}, 32'd1);

        // Invalid requests: misaligned and out of range.
        chk("err_clean_2", {31'd0, err}, 32'd0);
        send(1'b0, 32'h0000_0042, 32'd0);
        send(1'b0, 32'h0000_1000, 32'd0);
        drain();
        chk("err_set", {31'd0, err}, 32'd1);
        send(1'b1, 32'h0000_1000, 32'h5555_5555);
        send(1'b0, 32'h0000_0000, 32'd0);
        drain();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset with responses pending: everything buffered is discarded, RAM kept.
        mem_if.mem_rsp_rdy_i = 1'b0;
        send(1'b0, 32'h0, 32'd0);
        send(1'b0, 32'h4, 32'd0);
        send(1'b0, 32'h8, 32'd0);
        mem_if.mem_req_val_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("pending_rsp_val", {31'd0, mem_if.mem_rsp_val_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_val", {31'd0, mem_if.mem_rsp_val_o}, 32'd0);
        chk("rst_mid_rsp_data", mem_if.mem_rsp_data_o, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        chk("rst_mid_req_rdy", {31'd0, mem_if.mem_req_rdy_o}, 32'd1);
        mem_if.mem_rsp_rdy_i = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_rsp", {31'd0, mem_if.mem_rsp_val_o}, 32'd0);
        @(posedge clk); #1;
        send(1'b0, 32'h0000_0040, 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
